reg_share_arbiter: RTL and testbench

Round-robin arbiter that shares a single W-bit storage register among N requesters. A granted requester writes its data into the register on every cycle it holds the grant, up to MAX_HOLD captures. It sits between several producers and the downstream flop bank, and sequences which producer loads the register and for how long.

---
 rtl/reg_share_pkg.sv | 28 ++
 rtl/reg_share_arbiter_rr_pick.sv | 46 ++++
 rtl/reg_share_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_share_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/reg_share_pkg.sv
// Shared definitions for the register-sharing arbiter.
// Contents: the FSM state type, default parameter values, and helper
// functions that derive the counter and pointer widths from them.
package reg_share_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Pointer width: enough bits to index N requesters (at least one bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold-counter width: must represent 0..MAX_HOLD inclusive.
  function automatic int cnt_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_N);
  localparam int DEF_CNT_W = cnt_w(DEF_MAX_HOLD);

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Purely combinational round-robin picker.
// Searches req starting at last+1 and wraps from N-1 back to 0, so the
// requester granted most recently gets lowest priority.
// Ports:
//   req    - request vector
//   last   - index of the most recently granted requester
//   onehot - one-hot winner (all-zero if no request is set)
//   idx    - binary index of the winner
//   any    - at least one request is set
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  int sum_v;
  int cand_v;

  // Rotating priority search; the wrap is an explicit subtraction so
  // non-power-of-two N works correctly.
  always_comb begin
    idx    = '0;
    any    = 1'b0;
    sum_v  = 0;
    cand_v = 0;
    for (int i = 1; i <= N; i++) begin
      sum_v  = int'(last) + i;
      cand_v = (sum_v >= N) ? (sum_v - N) : sum_v;
      if (!any && req[cand_v[PTR_W-1:0]]) begin
        any = 1'b1;
        idx = cand_v[PTR_W-1:0];
      end else begin
        any = any;
      end
    end
    onehot = any ? (ONE << idx) : '0;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// A granted requester loads its data slice every cycle it keeps its request
// high, for at most MAX_HOLD captures. The grant then drops for at least
// one idle cycle before the next arbitration.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   req_i     - per-requester level request
//   data_i    - packed data, slice k = data_i[k*W +: W]
//   gnt_o     - registered one-hot grant (zero when idle)
//   q_o       - shared register contents
//   q_valid_o - one-cycle pulse after each capture
//   busy_o    - high while a grant is active
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] data_i,
  output logic [N-1:0]   gnt_o,
  output logic [W-1:0]   q_o,
  output logic           q_valid_o,
  output logic           busy_o
);

  localparam int PTR_W = ptr_w(N);
  localparam int CNT_W = cnt_w(MAX_HOLD);
  localparam logic [PTR_W-1:0] LAST_RST  = PTR_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_r;
  logic [N-1:0]     gnt_r;
  logic [W-1:0]     q_r;
  logic             q_valid_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] last_r;
  logic [PTR_W-1:0] owner_r;

  logic [N-1:0]     pick_onehot_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [W-1:0]     owner_data_s;

  rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req_i),
    .last   (last_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Data slice of the current grant holder.
  always_comb begin
    owner_data_s = data_i[owner_r*W +: W];
  end

  // Arbitration FSM, hold counter, priority pointer and shared register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      gnt_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      cnt_r     <= '0;
      last_r    <= LAST_RST;
      owner_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          q_valid_r <= 1'b0;
          if (pick_any_s) begin
            state_r <= GRANT;
            gnt_r   <= pick_onehot_s;
            owner_r <= pick_idx_s;
            cnt_r   <= '0;
          end else begin
            gnt_r <= '0;
          end
        end
        GRANT: begin
          if (req_i[owner_r]) begin
            q_r       <= owner_data_s;
            q_valid_r <= 1'b1;
            cnt_r     <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_FINAL) begin
              state_r <= IDLE;
              gnt_r   <= '0;
              last_r  <= owner_r;
            end
          end else begin
            // Early release: q_r keeps its last captured value.
            q_valid_r <= 1'b0;
            state_r   <= IDLE;
            gnt_r     <= '0;
            last_r    <= owner_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt_r     <= '0;
          q_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_r;
  assign q_o       = q_r;
  assign q_valid_o = q_valid_r;
  assign busy_o    = (state_r == GRANT);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: the stimulus side advances a
// behavioural model at each clock edge and queues the expected outputs;
// a monitor on the falling edge pops and compares.
module tb_reg_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   gnt_o;
  logic [W-1:0]   q_o;
  logic           q_valid_o;
  logic           busy_o;

  reg_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .data_i    (data_i),
    .gnt_o     (gnt_o),
    .q_o       (q_o),
    .q_valid_o (q_valid_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic         qv;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: who owns the register, how many captures so far,
  // who was served last, and the register/pulse values.
  int         m_owner;
  int         m_taken;
  int         m_last;
  logic [W-1:0] m_q;
  logic         m_qv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_taken = 0;
    m_last  = N - 1;
    m_q     = '0;
    m_qv    = 1'b0;
  endfunction

  // One clock edge of the arbitration rules, using the inputs present now.
  function automatic void model_step(input logic [N-1:0] r, input logic [N*W-1:0] d);
    int k;
    if (m_owner < 0) begin
      m_qv = 1'b0;
      for (int j = 1; j <= N; j++) begin
        k = (m_last + j) % N;
        if (r[k] && m_owner < 0) m_owner = k;
      end
      m_taken = 0;
    end else if (r[m_owner]) begin
      m_q  = d[m_owner*W +: W];
      m_qv = 1'b1;
      m_taken++;
      if (m_taken == MH) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else begin
      m_qv    = 1'b0;
      m_last  = m_owner;
      m_owner = -1;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [N-1:0] one;
    one    = {{(N-1){1'b0}}, 1'b1};
    e.gnt  = (m_owner >= 0) ? (one << m_owner) : '0;
    e.q    = m_q;
    e.qv   = m_qv;
    e.busy = (m_owner >= 0);
    return e;
  endfunction

  // Apply inputs, let one edge happen, queue the expected result.
  task automatic tick(input logic [N-1:0] r, input logic [N*W-1:0] d);
    req_i  = r;
    data_i = d;
    @(posedge clk);
    model_step(r, d);
    exp_q.push_back(model_out());
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, checked immediately.
  task automatic apply_reset();
    #3;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_q", 32'(q_o), 32'd0);
    chk("rst_qv", 32'(q_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    model_reset();
    req_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every falling edge compares outputs against the queued result.
  always @(negedge clk) begin
    exp_t e;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt", 32'(gnt_o), 32'(e.gnt));
      chk("busy", 32'(busy_o), 32'(e.busy));
      chk("q_valid", 32'(q_valid_o), 32'(e.qv));
      chk("q", 32'(q_o), 32'(e.q));
    end
  end

  initial begin
    logic [N-1:0] r;
    model_reset();
    #2;
    chk("init_gnt", 32'(gnt_o), 32'd0);
    chk("init_q", 32'(q_o), 32'd0);
    chk("init_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Grant requester 1, then reset mid-grant while gnt_o=0010.
    repeat (3) tick(4'b0010, 32'h0000_7700);
    apply_reset();

    // After reset requester 0 wins first; fairness under full load.
    repeat (22) tick(4'b1111, 32'h1312_1110);

    // Single continuous requester is re-granted after the gap.
    repeat (12) tick(4'b0100, 32'h00A5_0000);
    repeat (2) tick(4'b0000, 32'h0000_0000);

    // Early release after two captures.
    repeat (3) tick(4'b0001, 32'h0000_003C);
    repeat (3) tick(4'b0000, 32'h0000_0000);

    // Pointer wrap: after requester 2, 0011 goes to 0 then 1.
    repeat (6) tick(4'b0100, 32'h0055_0000);
    repeat (12) tick(4'b0011, 32'h0000_6677);

    // Random traffic with occasional asynchronous resets.
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      tick(r, 32'($urandom));
      if (c % 130 == 129) apply_reset();
    end

    @(negedge clk);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
